// File: rtl/cordic_pkg.sv
// cordic_pkg: shared definitions for the CORDIC arbiter slice.
//   Q_W         - Q16.16 fixed-point word width
//   TIMEOUT_DEF - default engine wait budget in cycles
//   state_t     - arbiter FSM encoding
//   rsp_t       - captured result (angle + timeout flag)
package cordic_pkg;
  localparam int Q_W         = 32;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [Q_W-1:0] theta;
    logic           err;
  } rsp_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i  - request vector
//   last_i - index granted last; search begins at last_i+1 (mod N)
//   gnt_o  - one-hot grant (zero when no request)
//   idx_o  - index of the granted request
//   any_o  - some request was granted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  int c;

  // Walk offsets 1..N from the last winner; first hit wins, so the last
  // winner itself is only picked when nobody else is asking.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    c     = 0;
    for (int off = 1; off <= N; off++) begin
      c = (int'(last_i) + off) % N;
      if (!any_o && req_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end
endmodule

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: shares one CORDIC atan2 engine among NUM_REQ requesters.
// One operation in flight at a time: IDLE grants, ISSUE pulses eng_start,
// WAIT collects the engine result (or times out), RESP holds the result
// until the consumer takes it.
//   req_valid/req_ready/req_x/req_y - per-requester operand handshake
//   rsp_valid/rsp_ready/rsp_id/rsp_theta/rsp_err - result handshake
//   eng_start/eng_x/eng_y - engine command; eng_theta/eng_valid/eng_busy - engine status
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = TIMEOUT_DEF,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [Q_W*NUM_REQ-1:0] req_x,
  input  logic [Q_W*NUM_REQ-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IW-1:0]          rsp_id,
  output logic [Q_W-1:0]         rsp_theta,
  output logic                   rsp_err,
  output logic                   eng_start,
  output logic [Q_W-1:0]         eng_x,
  output logic [Q_W-1:0]         eng_y,
  input  logic [Q_W-1:0]         eng_theta,
  input  logic                   eng_valid,
  input  logic                   eng_busy
);
  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   id_q, id_d;
  logic [Q_W-1:0]  x_q, x_d, y_q, y_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  rsp_t            rsp_q, rsp_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               gnt_any;

  logic [Q_W-1:0] op_x [NUM_REQ];
  logic [Q_W-1:0] op_y [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_x[i] = req_x[i*Q_W +: Q_W];
    assign op_y[i] = req_y[i*Q_W +: Q_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt),
    .idx_o  (gnt_idx),
    .any_o  (gnt_any)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    cnt_d     = cnt_q;
    rsp_d     = rsp_q;
    req_ready = '0;
    eng_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any && !eng_busy) begin
          // Ready is combinational from this cycle's valids; gate with
          // rst_n so nothing is accepted while reset is held.
          req_ready = gnt & {NUM_REQ{rst_n}};
          last_d    = gnt_idx;
          id_d      = gnt_idx;
          x_d       = op_x[gnt_idx];
          y_d       = op_y[gnt_idx];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_valid) begin
          rsp_d   = '{theta: eng_theta, err: 1'b0};
          state_d = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_d   = '{theta: '0, err: 1'b1};
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  // Operands stay in x_q/y_q until the next grant, so they remain stable
  // for the engine's delayed sample after eng_start.
  assign eng_x     = x_q;
  assign eng_y     = y_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_theta = rsp_q.theta;
  assign rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;
  localparam int NR = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [32*NR-1:0] req_x, req_y;
  logic            rsp_valid, rsp_ready;
  logic [1:0]      rsp_id;
  logic [31:0]     rsp_theta;
  logic            rsp_err;
  logic            eng_start;
  logic [31:0]     eng_x, eng_y;

  // behavioural atan2 engine standing in for the real CORDIC core
  logic        eng_en, eng_busy, eng_valid_m, samp, stray;
  logic [31:0] eng_theta_m, ex, ey;
  int          eng_lat, ecnt;
  wire         eng_valid_w = eng_valid_m | stray;
  wire  [31:0] eng_theta_w = stray ? 32'h1234_5678 : eng_theta_m;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] theta;
    logic        err;
    int          tol;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_theta(rsp_theta), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_theta(eng_theta_w), .eng_valid(eng_valid_w), .eng_busy(eng_busy)
  );

  function automatic logic [31:0] atan_q(logic [31:0] x, logic [31:0] y);
    real rx, ry;
    rx = $itor($signed(x)) / 65536.0;
    ry = $itor($signed(y)) / 65536.0;
    return 32'($rtoi($atan2(ry, rx) * 65536.0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_busy <= 1'b0; eng_valid_m <= 1'b0; samp <= 1'b0; ecnt <= 0;
      ex <= '0; ey <= '0; eng_theta_m <= '0;
    end else begin
      eng_valid_m <= 1'b0;
      if (samp) begin ex <= eng_x; ey <= eng_y; samp <= 1'b0; end
      if (eng_start) begin
        eng_busy <= 1'b1; samp <= 1'b1; ecnt <= eng_lat;
      end else if (eng_busy && ecnt > 0) begin
        ecnt <= ecnt - 1;
      end else if (eng_busy) begin
        eng_busy <= 1'b0;
        if (eng_en) begin eng_valid_m <= 1'b1; eng_theta_m <= atan_q(ex, ey); end
      end
    end
  end

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", n, act, exp);
    end
  endtask

  task automatic chk_tol(string n, logic [31:0] act, logic [31:0] exp, int tol);
    int d;
    d = $signed(act) - $signed(exp);
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h tol=%0d", n, act, exp, tol);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (req_ready != '0) begin
        checks++;
        if (!$onehot(req_ready) || rsp_valid) begin
          failures++;
          $display("FAIL ready_onehot act=%b rsp_valid=%b exp=onehot_outside_resp", req_ready, rsp_valid);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp act_id=%0d theta=%0h exp=none", rsp_id, rsp_theta);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_err", 64'(rsp_err), 64'(e.err));
          chk_tol("rsp_theta", rsp_theta, e.theta, e.tol);
        end
      end
    end
  end

  task automatic push(int id, logic [31:0] th, logic err, int tol);
    exp_t e;
    e.id = id; e.theta = th; e.err = err; e.tol = tol;
    sb.push_back(e);
  endtask

  task automatic set_op(int i, logic [31:0] x, logic [31:0] y);
    req_x[i*32 +: 32] = x;
    req_y[i*32 +: 32] = y;
  endtask

  task automatic wait_grant(output logic [NR-1:0] g);
    g = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin g = req_ready; return; end
    end
    checks++; failures++;
    $display("FAIL grant_timeout act=none exp=grant");
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500 && sb.size() != 0; k++) @(negedge clk);
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_req(int i, logic [31:0] x, logic [31:0] y,
                        logic [31:0] th, logic err, int tol);
    logic [NR-1:0] g;
    set_op(i, x, y);
    @(posedge clk); #1 req_valid[i] = 1'b1;
    wait_grant(g);
    chk("grant", 64'(g), 64'(1 << i));
    push(i, th, err, tol);
    @(posedge clk); #1 req_valid[i] = 1'b0;
  endtask

  initial begin
    logic [NR-1:0] g;
    logic [1:0]    h_id;
    logic [31:0]   h_th;
    logic          h_err;
    int            s;

    rst_n = 1'b0; req_valid = '1; req_x = '0; req_y = '0;
    rsp_ready = 1'b1; eng_en = 1'b1; eng_lat = 4; stray = 1'b0;
    set_op(0, 32'h0001_0000, 32'h0000_0000);
    set_op(1, 32'h0000_0000, 32'h0001_0000);
    set_op(2, 32'hFFFF_0000, 32'h0000_0000);
    set_op(3, 32'h0000_0000, 32'hFFFF_0000);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_theta", 64'(rsp_theta), 64'd0);
    chk("rst_eng_start", 64'(eng_start), 64'd0);
    chk("rst_eng_xy", {eng_x, eng_y}, 64'd0);

    // all four valid: 0,1,2,3,0
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_order", 64'(g), 64'(1 << (k % 4)));
      case (k % 4)
        0: push(0, 32'h0000_0000, 1'b0, 8);
        1: push(1, 32'h0001_921F, 1'b0, 16);
        2: push(2, 32'h0003_243F, 1'b0, 16);
        default: push(3, 32'hFFFE_6DE1, 1'b0, 16);
      endcase
      @(posedge clk);
      if (k == 4) begin #1 req_valid = '0; end
    end
    wait_drain();

    // single request, grant -> eng_start latency
    do_req(0, 32'h0001_0000, 32'h0001_0000, 32'h0000_C90F, 1'b0, 8);
    @(negedge clk);
    chk("start_lat", 64'(eng_start), 64'd1);
    chk("start_ops", {eng_x, eng_y}, 64'h0001_0000_0001_0000);
    @(negedge clk);
    chk("start_pulse", 64'(eng_start), 64'd0);
    wait_drain();

    // quadrant II
    do_req(2, 32'hFFFF_0000, 32'h0001_0000, 32'h0002_5B2F, 1'b0, 16);
    wait_drain();

    // timeout, then a normal request
    eng_en = 1'b0;
    do_req(3, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 0);
    @(negedge clk);
    chk("to_start", 64'(eng_start), 64'd1);
    s = cyc;
    for (int k = 0; k < TO + 10 && !rsp_valid; k++) @(negedge clk);
    chk("to_latency", 64'(cyc - s), 64'(TO + 1));
    wait_drain();
    eng_en = 1'b1;
    do_req(0, 32'h0001_0000, 32'h0000_0000, 32'h0, 1'b0, 8);
    wait_drain();

    // backpressure with stray eng_valid during RESP
    rsp_ready = 1'b0;
    set_op(1, 32'h0001_0000, 32'h0001_0000);
    set_op(3, 32'h0000_0000, 32'h0001_0000);
    @(posedge clk); #1 req_valid = 4'b1010;
    wait_grant(g);
    chk("bp_grant", 64'(g), 64'b0010);
    push(1, 32'h0000_C90F, 1'b0, 8);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    for (int k = 0; k < 100 && !rsp_valid; k++) @(negedge clk);
    h_id = rsp_id; h_th = rsp_theta; h_err = rsp_err;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 stray = (k == 3);
      @(negedge clk);
      chk("bp_hold", {29'd0, rsp_valid, rsp_id, rsp_err, rsp_theta}, {29'd0, 1'b1, h_id, h_err, h_th});
      chk("bp_no_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 stray = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_regrant", 64'(req_ready), 64'b1000);
    push(3, 32'h0001_921F, 1'b0, 16);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_drain();

    // reset in WAIT
    eng_lat = 8;
    do_req(2, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 0);
    void'(sb.pop_back());
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp", {rsp_valid, rsp_err, rsp_id, rsp_theta}, 64'd0);
    chk("mid_rst_eng", {eng_start, req_ready, eng_x, eng_y}, 64'd0);
    req_valid = '1;
    set_op(0, 32'h0000_0000, 32'h0001_0000);
    repeat (2) @(negedge clk);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_grant(g);
    chk("post_rst_grant", 64'(g), 64'b0001);
    push(0, 32'h0001_921F, 1'b0, 16);
    @(posedge clk); #1 req_valid = '0;
    wait_drain();
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
